clock_freq_meter: RTL and testbench

CLOCK_FREQ_METER -- requirements
Module: clock_freq_meter

---
 rtl/clock_freq_meter.sv | 166 ++++++++++++++++
 tb/tb_clock_freq_meter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_freq_meter.sv
// clock_freq_meter: measures the half-period of desired_clock in basys_clock
// cycles and reports lock against expected_m and loss of the clock (timeout).
// Optional feature macro: FREQ_METER_TOL_EN (accept measurements within +/-1).
//
// Handshake: meas_valid is a single-cycle strobe with no ready; measured_m is
// stable from that cycle until the next strobe.
module clock_freq_meter #(
    parameter int LOCK_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        basys_clock,
    input  logic        reset_n,
    input  logic        desired_clock,
    input  logic [31:0] expected_m,
    output logic [31:0] measured_m,
    output logic        meas_valid,
    output logic        locked,
    output logic        timeout,
    output logic [1:0]  state_dbg
);

    localparam int          CW      = $clog2(LOCK_COUNT + 1);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t          state, next_state;
    logic [CW-1:0]   match_cnt, next_match_cnt;
    logic [31:0]     cnt;
    logic            sync1, sync2, sync3;
    logic            edge_det;
    logic            hit_to;
    logic            is_match;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge basys_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= desired_clock;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Either edge of the synchronised clock restarts a measurement.
    assign edge_det = sync2 ^ sync3;

    // Cycle counter: cleared on an edge, otherwise counts up and saturates.
    always_ff @(posedge basys_clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 32'd0;
        end else if (edge_det) begin
            cnt <= 32'd0;
        end else if (cnt != 32'hFFFF_FFFF) begin
            cnt <= cnt + 32'd1;
        end
    end

    // An edge in the threshold cycle takes priority over the timeout.
    assign hit_to = (cnt == TO_LAST) && !edge_det;

    // Match rule applied to the freshly loaded measurement.
`ifdef FREQ_METER_TOL_EN
    always_comb begin
        is_match = (measured_m == expected_m);
        if ((measured_m != 32'hFFFF_FFFF) && (measured_m + 32'd1 == expected_m))
            is_match = 1'b1;
        if ((measured_m != 32'd0) && (measured_m - 32'd1 == expected_m))
            is_match = 1'b1;
    end
`else
    always_comb begin
        is_match = (measured_m == expected_m);
    end
`endif

    // Measurement register and strobe; the reference edge in WAIT only starts the count.
    always_ff @(posedge basys_clock or negedge reset_n) begin
        if (!reset_n) begin
            measured_m <= 32'd0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (edge_det && (state != S_WAIT)) begin
                measured_m <= cnt;
                meas_valid <= 1'b1;
            end
        end
    end

    // Timeout flag: set on threshold while measuring, cleared by the next edge.
    always_ff @(posedge basys_clock or negedge reset_n) begin
        if (!reset_n) begin
            timeout <= 1'b0;
        end else if (edge_det) begin
            timeout <= 1'b0;
        end else if (hit_to && (state != S_WAIT)) begin
            timeout <= 1'b1;
        end
    end

    // FSM state and match counter register.
    always_ff @(posedge basys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_WAIT;
            match_cnt <= '0;
        end else begin
            state     <= next_state;
            match_cnt <= next_match_cnt;
        end
    end

    // Next-state logic; comparisons use the registered measurement while meas_valid is high,
    // so locked follows one cycle after the deciding strobe.
    always_comb begin
        next_state     = state;
        next_match_cnt = match_cnt;
        case (state)
            S_WAIT: begin
                next_match_cnt = '0;
                if (edge_det) next_state = S_ACQ;
            end
            S_ACQ: begin
                if (hit_to) begin
                    next_state     = S_WAIT;
                    next_match_cnt = '0;
                end else if (meas_valid) begin
                    if (is_match) begin
                        if (match_cnt >= CW'(LOCK_COUNT - 1)) begin
                            next_state     = S_LOCK;
                            next_match_cnt = '0;
                        end else begin
                            next_match_cnt = match_cnt + 1'b1;
                        end
                    end else begin
                        next_match_cnt = '0;
                    end
                end
            end
            S_LOCK: begin
                if (hit_to) begin
                    next_state     = S_WAIT;
                    next_match_cnt = '0;
                end else if (meas_valid && !is_match) begin
                    next_state     = S_ACQ;
                    next_match_cnt = '0;
                end
            end
            default: begin
                next_state     = S_WAIT;
                next_match_cnt = '0;
            end
        endcase
    end

    assign locked    = (state == S_LOCK);
    assign state_dbg = state;

endmodule

// File: tb/tb_clock_freq_meter.sv
// Bench for clock_freq_meter: drives desired_clock edges with chosen spacings
// and compares against a per-edge model of the measure/lock/timeout rules.
module tb_clock_freq_meter;

    localparam int LOCK_COUNT = 4;
    localparam int TO         = 3000;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dclk = 1'b0;
    logic [31:0] exp_m = 32'd0;
    logic [31:0] measured_m;
    logic        meas_valid;
    logic        locked;
    logic        timeout;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    clock_freq_meter #(.LOCK_COUNT(LOCK_COUNT), .TIMEOUT_CYCLES(TO)) dut (
        .basys_clock  (clk),
        .reset_n      (rst_n),
        .desired_clock(dclk),
        .expected_m   (exp_m),
        .measured_m   (measured_m),
        .meas_valid   (meas_valid),
        .locked       (locked),
        .timeout      (timeout),
        .state_dbg    (state_dbg)
    );

    // scoreboard / model state
    int          checks = 0;
    int          errors = 0;
    int          since = 0;      // negedges since the last desired_clock toggle
    int          m_state = 0;    // 0 = no reference, 1 = acquiring, 2 = locked
    int          m_cnt = 0;
    logic [31:0] last_meas = 32'd0;
    logic [31:0] exp_q[$];

    function automatic bit model_match(input logic [31:0] m, input logic [31:0] e);
`ifdef FREQ_METER_TOL_EN
        longint d;
        d = longint'(m) - longint'(e);
        return (d >= -1) && (d <= 1);
`else
        return m == e;
`endif
    endfunction

    // Wait until 'gap' cycles after the previous toggle, toggle, and check the outcome.
    task automatic do_edge(input int gap);
        int          prev_state;
        bit          exp_valid;
        logic [31:0] m;
        logic [31:0] want;
        prev_state = m_state;
        while (since < gap) begin
            @(negedge clk);
            since++;
            if (prev_state != 0 && gap >= TO + 4 && since == TO + 3) begin
                checks++;
                if (timeout !== 1'b1 || locked !== 1'b0 || measured_m !== last_meas) begin
                    errors++;
                    $display("FAIL timeout_set: timeout=%0b locked=%0b measured_m=%0d want 1/0/%0d",
                             timeout, locked, measured_m, last_meas);
                end
            end
        end
        if (m_state != 0 && gap > TO) begin
            m_state = 0;
            m_cnt   = 0;
        end
        exp_valid = (m_state != 0);
        if (m_state == 0) begin
            m_state = 1;
        end else begin
            m = 32'(gap - 1);
            exp_q.push_back(m);
            last_meas = m;
            if (model_match(m, exp_m)) begin
                if (m_state == 1) begin
                    m_cnt++;
                    if (m_cnt >= LOCK_COUNT) begin
                        m_state = 2;
                        m_cnt   = 0;
                    end
                end
            end else begin
                m_state = 1;
                m_cnt   = 0;
            end
        end
        dclk  = ~dclk;
        since = 0;
        repeat (3) begin
            @(negedge clk);
            since++;
        end
        checks++;
        want = exp_valid ? exp_q.pop_front() : measured_m;
        if (meas_valid !== exp_valid || timeout !== 1'b0 || (exp_valid && measured_m !== want)) begin
            errors++;
            $display("FAIL edge_meas gap=%0d: valid=%0b timeout=%0b measured_m=%0d want valid=%0b timeout=0 measured_m=%0d",
                     gap, meas_valid, timeout, measured_m, exp_valid, want);
        end
        @(negedge clk);
        since++;
        checks++;
        if (locked !== (m_state == 2) || meas_valid !== 1'b0) begin
            errors++;
            $display("FAIL edge_lock gap=%0d: locked=%0b valid=%0b want locked=%0b valid=0",
                     gap, locked, meas_valid, (m_state == 2));
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (measured_m !== 32'd0 || meas_valid !== 1'b0 || locked !== 1'b0 ||
            timeout !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: m=%0d v=%0b l=%0b t=%0b s=%0d want all 0",
                     measured_m, meas_valid, locked, timeout, state_dbg);
        end
        rst_n = 1'b1;
        since = 0;
    endtask

    task automatic test_lock_2500;
        exp_m = 32'd2499;
        do_edge(10);
        for (int i = 0; i < 6; i++) do_edge(2500);
    endtask

    task automatic test_retune;
        int r;
        r = $urandom_range(300, 60);
        exp_m = 32'(r);
        for (int i = 0; i < 6; i++) do_edge(r + 1);
        exp_m = 32'(2 * r);
        do_edge(r + 1);
        for (int i = 0; i < 6; i++) do_edge(2 * r + 1);
    endtask

    task automatic test_random;
        int r;
        int g;
        r = $urandom_range(300, 40);
        exp_m = 32'(r);
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(5, 0))
                0:       g = r;
                1:       g = r + 2;
                2:       g = $urandom_range(400, 8);
                default: g = r + 1;
            endcase
            do_edge(g);
        end
    endtask

    task automatic test_tolerance;
        int r;
        r = $urandom_range(200, 40);
        exp_m = 32'(r);
        for (int i = 0; i < 6; i++) do_edge(r + 2);
        for (int i = 0; i < 6; i++) do_edge(r);
    endtask

    task automatic test_timeout;
        exp_m = 32'd99;
        for (int i = 0; i < 6; i++) do_edge(100);
        do_edge(TO + 20);
        do_edge(100);
        do_edge(100);
    endtask

    task automatic test_edge_at_threshold;
        exp_m = 32'(TO - 1);
        do_edge(TO);
        do_edge(TO);
        do_edge(TO + 1);
        do_edge(TO);
    endtask

    task automatic test_reset_mid;
        exp_m = 32'd149;
        for (int i = 0; i < 6; i++) do_edge(150);
        if (dclk) do_edge(150);
        repeat (20) begin
            @(negedge clk);
            since++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (measured_m !== 32'd0 || meas_valid !== 1'b0 || locked !== 1'b0 ||
            timeout !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: m=%0d v=%0b l=%0b t=%0b s=%0d want all 0",
                     measured_m, meas_valid, locked, timeout, state_dbg);
        end
        #6;
        rst_n = 1'b1;
        m_state   = 0;
        m_cnt     = 0;
        last_meas = 32'd0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) do_edge(150);
    endtask

    initial begin
        test_reset;
        test_lock_2500;
        test_retune;
        test_random;
        test_tolerance;
        test_timeout;
        test_edge_at_threshold;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
